pdm_decimator: RTL and testbench

- Capture stage upstream of the delay-buffer/AudioOutput path.
- Consumes the synchronized 1-bit PDM stream from the on-board microphone and converts it to 16-bit signed PCM using a 3rd-order CIC decimator, R = 64 (3.072 MHz → 48 kHz).
- Writes each PCM sample into the delay-buffer BRAM write port at a wrapping address.

---
 rtl/pdm_pkg.sv | 17 +
 rtl/cic_comb_stage.sv | 29 ++
 rtl/pdm_decimator.sv | 146 ++++++++++++++
 tb/tb_pdm_decimator.sv | 200 ++++++++++++++++++++
 4 files changed

// File: rtl/pdm_pkg.sv
// pdm_pkg: shared constants for the PDM-to-PCM capture path.
//   CIC_ORDER   number of integrator/comb pairs in the CIC decimator
//   ACC_W       integrator/comb word width (wraps by design)
//   PCM_W       output sample width
//   OUT_SHIFT   arithmetic right shift applied to the comb output
//   PCM_MAX/MIN saturation bounds of the signed PCM sample
package pdm_pkg;

  localparam int CIC_ORDER = 3;
  localparam int ACC_W     = 20;
  localparam int PCM_W     = 16;
  localparam int OUT_SHIFT = 3;

  localparam logic signed [PCM_W-1:0] PCM_MAX = 16'sh7FFF;
  localparam logic signed [PCM_W-1:0] PCM_MIN = 16'sh8000;

endpackage

// File: rtl/cic_comb_stage.sv
// cic_comb_stage: one comb section of the CIC decimator.
//   clk    system clock, rising edge
//   reset  synchronous active-high reset, clears the delay register
//   stb    decimated-rate strobe; the delay register loads x on it
//   x      comb input (signed)
//   y      x minus the stored delay (combinational, wraps modulo 2^DATA_W)
module cic_comb_stage #(
  parameter int DATA_W = 20
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     stb,
  input  logic signed [DATA_W-1:0] x,
  output logic signed [DATA_W-1:0] y
);

  logic signed [DATA_W-1:0] dly_p1;

  assign y = x - dly_p1;

  always_ff @(posedge clk) begin
    if (reset) begin
      dly_p1 <= '0;
    end else if (stb) begin
      dly_p1 <= x;
    end
  end

endmodule

// File: rtl/pdm_decimator.sv
// pdm_decimator: converts the synchronized 1-bit PDM microphone stream into
// 16-bit signed PCM with a 3rd-order CIC decimator (R = DECIM) and writes each
// sample into the delay-buffer BRAM at a wrapping address.
//   clk        system clock, rising edge
//   reset      synchronous active-high reset, clears all state
//   pdm_en     one-cycle strobe marking a valid PDM bit
//   pdm_data   PDM bit, 1 -> +1, 0 -> -1
//   run        capture enable; when low the filter is frozen
//   pcm_valid  one-cycle pulse, new sample on pcm_data
//   pcm_data   signed PCM sample, held until the next sample
//   wr_en      BRAM write enable (same as pcm_valid)
//   wr_addr    BRAM write address belonging to the current wr_en
//   wr_data    BRAM write data (same as pcm_data)
module pdm_decimator
  import pdm_pkg::*;
#(
  parameter int DECIM     = 64,
  parameter int ADDR_W    = 16,
  parameter int BUF_DEPTH = 65536
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    pdm_en,
  input  logic                    pdm_data,
  input  logic                    run,
  output logic                    pcm_valid,
  output logic signed [PCM_W-1:0] pcm_data,
  output logic                    wr_en,
  output logic [ADDR_W-1:0]       wr_addr,
  output logic signed [PCM_W-1:0] wr_data
);

  localparam logic [5:0]        CNT_LAST  = 6'(DECIM - 1);
  localparam logic [ADDR_W-1:0] ADDR_LAST = ADDR_W'(BUF_DEPTH - 1);

  function automatic logic signed [PCM_W-1:0] sat_pcm(input logic signed [ACC_W-1:0] v);
    logic signed [ACC_W-1:0] s;
    logic signed [ACC_W-1:0] hi;
    logic signed [ACC_W-1:0] lo;
    s  = v >>> OUT_SHIFT;
    hi = {{(ACC_W-PCM_W){PCM_MAX[PCM_W-1]}}, PCM_MAX};
    lo = {{(ACC_W-PCM_W){PCM_MIN[PCM_W-1]}}, PCM_MIN};
    if (s > hi) begin
      sat_pcm = PCM_MAX;
    end else if (s < lo) begin
      sat_pcm = PCM_MIN;
    end else begin
      sat_pcm = s[PCM_W-1:0];
    end
  endfunction

  logic signed [1:0]       x_p0;
  logic signed [ACC_W-1:0] x_ext_p0;
  logic signed [ACC_W-1:0] i1_p0, i2_p0, i3_p0;
  logic signed [ACC_W-1:0] i1_nxt, i2_nxt, i3_nxt;
  logic [5:0]              cnt_p0;
  logic                    dec_stb_p1;
  logic signed [ACC_W-1:0] comb_p1 [CIC_ORDER+1];
  logic [1:0]              warm_p2;
  logic signed [PCM_W-1:0] pcm_p2;
  logic                    vld_p2;
  logic [ADDR_W-1:0]       addr_p2;

  // ---- stage p0: input mapping, integrators, decimation counter ----
  assign x_p0     = pdm_data ? 2'sb01 : 2'sb11;
  assign x_ext_p0 = {{(ACC_W-2){x_p0[1]}}, x_p0};

  // Integrators are chained within the cycle so the closing bit is fully
  // absorbed into i3 on the same edge that raises dec_stb.
  always_comb begin
    i1_nxt = i1_p0 + x_ext_p0;
    i2_nxt = i2_p0 + i1_nxt;
    i3_nxt = i3_p0 + i2_nxt;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      i1_p0      <= '0;
      i2_p0      <= '0;
      i3_p0      <= '0;
      cnt_p0     <= '0;
      dec_stb_p1 <= 1'b0;
    end else begin
      dec_stb_p1 <= 1'b0;
      if (!run) begin
        cnt_p0 <= '0;
      end else if (pdm_en) begin
        i1_p0 <= i1_nxt;
        i2_p0 <= i2_nxt;
        i3_p0 <= i3_nxt;
        if (cnt_p0 == CNT_LAST) begin
          cnt_p0     <= '0;
          dec_stb_p1 <= 1'b1;
        end else begin
          cnt_p0 <= cnt_p0 + 6'd1;
        end
      end
    end
  end

  // ---- stage p1: comb section at the decimated rate ----
  assign comb_p1[0] = i3_p0;

  for (genvar g = 0; g < CIC_ORDER; g++) begin : g_comb
    cic_comb_stage #(
      .DATA_W (ACC_W)
    ) u_comb (
      .clk   (clk),
      .reset (reset),
      .stb   (dec_stb_p1),
      .x     (comb_p1[g]),
      .y     (comb_p1[g+1])
    );
  end

  // ---- stage p2: scaling, warm-up gating, write address ----
  always_ff @(posedge clk) begin
    if (reset) begin
      pcm_p2  <= '0;
      vld_p2  <= 1'b0;
      warm_p2 <= '0;
      addr_p2 <= '0;
    end else begin
      vld_p2 <= 1'b0;
      if (dec_stb_p1) begin
        pcm_p2 <= sat_pcm(comb_p1[CIC_ORDER]);
        // The first outputs come from a filter whose history is still zero.
        if (warm_p2 == 2'd3) begin
          vld_p2 <= 1'b1;
        end else begin
          warm_p2 <= warm_p2 + 2'd1;
        end
      end
      if (vld_p2) begin
        addr_p2 <= (addr_p2 == ADDR_LAST) ? '0 : addr_p2 + ADDR_W'(1);
      end
    end
  end

  assign pcm_valid = vld_p2;
  assign wr_en     = vld_p2;
  assign pcm_data  = pcm_p2;
  assign wr_data   = pcm_p2;
  assign wr_addr   = addr_p2;

endmodule

// File: tb/tb_pdm_decimator.sv
// tb_pdm_decimator: directed self-checking bench for pdm_decimator.
// Two instances share the stimulus: one with the default 64K-word buffer and
// one with an 8-word buffer to exercise the address wrap.
module tb_pdm_decimator;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic               reset;
  logic               pdm_en;
  logic               pdm_data;
  logic               run;
  logic               pcm_valid;
  logic signed [15:0] pcm_data;
  logic               wr_en;
  logic [15:0]        wr_addr;
  logic signed [15:0] wr_data;

  logic               pcm_valid8;
  logic signed [15:0] pcm_data8;
  logic               wr_en8;
  logic [2:0]         wr_addr8;
  logic signed [15:0] wr_data8;

  pdm_decimator dut (
    .clk       (clk),
    .reset     (reset),
    .pdm_en    (pdm_en),
    .pdm_data  (pdm_data),
    .run       (run),
    .pcm_valid (pcm_valid),
    .pcm_data  (pcm_data),
    .wr_en     (wr_en),
    .wr_addr   (wr_addr),
    .wr_data   (wr_data)
  );

  pdm_decimator #(
    .DECIM     (64),
    .ADDR_W    (3),
    .BUF_DEPTH (8)
  ) dut8 (
    .clk       (clk),
    .reset     (reset),
    .pdm_en    (pdm_en),
    .pdm_data  (pdm_data),
    .run       (run),
    .pcm_valid (pcm_valid8),
    .pcm_data  (pcm_data8),
    .wr_en     (wr_en8),
    .wr_addr   (wr_addr8),
    .wr_data   (wr_data8)
  );

  int n_cmp = 0;
  int n_bad = 0;
  int obs   = 0;
  int n_wr  = 0;
  int n_pv  = 0;
  int last_wr_obs = 0;
  int last_pcm    = 0;
  int last_wd     = 0;
  int last_addr   = 0;
  int last_addr8  = 0;
  int exp_addr    = 0;

  task automatic check(input string tag, input int got, input int exp);
    n_cmp++;
    if (got != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Drive one cycle of inputs, then observe the outputs at the falling edge.
  task automatic tick(input logic en, input logic b);
    int v;
    pdm_en   = en;
    pdm_data = b;
    @(negedge clk);
    obs++;
    if (pcm_valid) n_pv++;
    if (wr_en) begin
      n_wr++;
      last_wr_obs = obs;
      v = pcm_data;  last_pcm = v;
      v = wr_data;   last_wd  = v;
      last_addr  = int'(wr_addr);
      last_addr8 = int'(wr_addr8);
    end
  endtask

  // 64 strobes (mode 0: all zeros, 1: all ones, 2: alternating 1/0) with
  // 'gap' clocks between strobes; at least 3 idle clocks follow the last one.
  task automatic window(input string tag, input int gap, input int mode,
                        input bit exp_v, input bit chk_pcm, input int exp_pcm);
    int   wr0;
    int   pv0;
    int   s_obs;
    int   tail;
    logic b;
    wr0   = n_wr;
    pv0   = n_pv;
    s_obs = 0;
    for (int k = 0; k < 64; k++) begin
      b = (mode == 2) ? ~k[0] : mode[0];
      tick(1'b1, b);
      if (k == 63) s_obs = obs;
      tail = (k == 63) ? ((gap < 3) ? 3 : gap) : gap;
      for (int g = 1; g < tail; g++) tick(1'b0, 1'b0);
    end
    check($sformatf("%s_wr_count", tag), n_wr - wr0, exp_v ? 1 : 0);
    check($sformatf("%s_valid_count", tag), n_pv - pv0, exp_v ? 1 : 0);
    if (exp_v && (n_wr - wr0 == 1)) begin
      check($sformatf("%s_latency_clk", tag), last_wr_obs - s_obs + 1, 2);
      if (chk_pcm) check($sformatf("%s_pcm", tag), last_pcm, exp_pcm);
      check($sformatf("%s_wr_data", tag), last_wd, last_pcm);
      check($sformatf("%s_wr_addr", tag), last_addr, exp_addr);
      check($sformatf("%s_wr_addr8", tag), last_addr8, exp_addr % 8);
      exp_addr++;
    end
  endtask

  task automatic check_zero(input string tag);
    int v;
    check($sformatf("%s_pcm_valid", tag), int'(pcm_valid), 0);
    check($sformatf("%s_wr_en", tag), int'(wr_en), 0);
    v = pcm_data;
    check($sformatf("%s_pcm_data", tag), v, 0);
    v = wr_data;
    check($sformatf("%s_wr_data", tag), v, 0);
    check($sformatf("%s_wr_addr", tag), int'(wr_addr), 0);
    check($sformatf("%s_wr_addr8", tag), int'(wr_addr8), 0);
  endtask

  initial begin
    int wr0;
    reset    = 1'b1;
    run      = 1'b0;
    pdm_en   = 1'b0;
    pdm_data = 1'b0;
    repeat (3) tick(1'b0, 1'b0);
    check_zero("reset");

    reset = 1'b0;
    run   = 1'b1;
    tick(1'b0, 1'b0);

    // Constant ones, strobe every 33 clk: 3 silent decimations, then full scale.
    for (int w = 0; w < 3; w++) window($sformatf("ones_warm%0d", w), 33, 1, 1'b0, 1'b0, 0);
    for (int w = 0; w < 12; w++) window($sformatf("ones%0d", w), 33, 1, 1'b1, 1'b1, 32767);

    // Constant zeros: the first three windows still carry old history.
    for (int w = 0; w < 3; w++) window($sformatf("zeros_settle%0d", w), 2, 0, 1'b1, 1'b0, 0);
    for (int w = 0; w < 2; w++) window($sformatf("zeros%0d", w), 2, 0, 1'b1, 1'b1, -32768);

    // Alternating bits with back-to-back strobes.
    for (int w = 0; w < 3; w++) window($sformatf("alt_settle%0d", w), 1, 2, 1'b1, 1'b0, 0);
    for (int w = 0; w < 2; w++) window($sformatf("alt%0d", w), 1, 2, 1'b1, 1'b1, 0);

    // Reset at count 40, with a strobe coincident with reset.
    for (int k = 0; k < 40; k++) begin
      tick(1'b1, 1'b1);
      tick(1'b0, 1'b0);
    end
    reset = 1'b1;
    tick(1'b1, 1'b1);
    reset = 1'b0;
    tick(1'b0, 1'b0);
    tick(1'b0, 1'b0);
    check_zero("mid_reset");
    exp_addr = 0;
    for (int w = 0; w < 3; w++) window($sformatf("rst_warm%0d", w), 2, 1, 1'b0, 1'b0, 0);
    window("rst_first", 2, 1, 1'b1, 1'b1, 32767);
    window("rst_second", 2, 1, 1'b1, 1'b1, 32767);

    // Drop run mid-decimation for 100 strobes, then resume.
    for (int k = 0; k < 20; k++) begin
      tick(1'b1, 1'b1);
      tick(1'b0, 1'b0);
    end
    run = 1'b0;
    wr0 = n_wr;
    for (int k = 0; k < 100; k++) begin
      tick(1'b1, 1'b1);
      tick(1'b0, 1'b0);
    end
    check("run_low_wr_count", n_wr - wr0, 0);
    check("run_low_wr_addr", int'(wr_addr), exp_addr);
    check("run_low_wr_addr8", int'(wr_addr8), exp_addr % 8);
    run = 1'b1;
    tick(1'b0, 1'b0);
    for (int w = 0; w < 3; w++) window($sformatf("resume%0d", w), 2, 1, 1'b1, 1'b0, 0);
    window("resume_steady", 2, 1, 1'b1, 1'b1, 32767);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
